// File: rtl/slink_axi_chan_arb_if.sv
// Channel-side and output-side handshake bundle of the S-Link A2L channel arbiter.
// master = traffic source / output sink, slave = the arbiter itself.
interface slink_axi_chan_arb_if #(
   parameter int NUM_CH    = 3,
   parameter int DATA_W    = 120,
   parameter int WEIGHT_W  = 4,
   parameter int MAX_OUTST = 8
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic                         enable;
   logic [NUM_CH-1:0]            ch_valid;
   logic [NUM_CH-1:0]            ch_ready;
   logic [NUM_CH-1:0]            ch_last;
   logic [NUM_CH*DATA_W-1:0]     ch_data;
   logic [NUM_CH*WEIGHT_W-1:0]   ch_weight;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_W-1:0]            out_data;
   logic [CH_W-1:0]              out_ch;
   logic                         out_last;
   logic [CNT_W-1:0]             outst_cnt;

   modport master (
      output enable, ch_valid, ch_last, ch_data, ch_weight, out_ready,
      input  ch_ready, out_valid, out_data, out_ch, out_last, outst_cnt
   );

   modport slave (
      input  enable, ch_valid, ch_last, ch_data, ch_weight, out_ready,
      output ch_ready, out_valid, out_data, out_ch, out_last, outst_cnt
   );
endinterface

// File: rtl/slink_axi_chan_arb.sv
// Weighted round-robin packet arbiter with optional SRC->DST packet ordering rule.
// Latency: 1 cycle from accepted channel beat to registered output; one idle arbitration cycle per turn.
// Backpressure: output stage holds while out_valid && !out_ready; channel ready only when the stage can load.
module slink_axi_chan_arb #(
   parameter int NUM_CH     = 3,
   parameter int DATA_W     = 120,
   parameter int WEIGHT_W   = 4,
   parameter int DEP_EN     = 1,
   parameter int DEP_SRC_CH = 0,
   parameter int DEP_DST_CH = 1,
   parameter int MAX_OUTST  = 8
) (
   input logic                 axi_clk,
   input logic                 axi_reset,
   slink_axi_chan_arb_if.slave bus
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state;
   logic [CH_W-1:0]     grant;
   logic [CH_W-1:0]     rr_ptr;
   logic [CH_W-1:0]     next_ptr;
   logic [CH_W-1:0]     pick;
   logic                pick_vld;
   logic [WEIGHT_W-1:0] credit;
   logic [WEIGHT_W-1:0] pick_weight;
   logic                mid_pkt;
   logic                loadable;
   logic                accept;
   logic                beat_last;
   logic [NUM_CH-1:0]   elig;
   logic [NUM_CH-1:0]   ready;
   logic [CNT_W-1:0]    cnt;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [CH_W-1:0]     out_ch_q;
   logic                out_last_q;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         elig[i] = bus.ch_valid[i] && bus.enable;
         if (DEP_EN != 0 && i == DEP_DST_CH && cnt == '0)
            elig[i] = 1'b0;
         if (DEP_EN != 0 && i == DEP_SRC_CH && cnt == CNT_W'(MAX_OUTST))
            elig[i] = 1'b0;
      end
   end

   // First eligible channel at or after the rotation pointer, wrapping at NUM_CH-1.
   always_comb begin
      int j;
      j        = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_CH)
            j = j - NUM_CH;
         if (!pick_vld && elig[j]) begin
            pick_vld = 1'b1;
            pick     = CH_W'(j);
         end
      end
   end

   assign pick_weight = bus.ch_weight[int'(pick)*WEIGHT_W +: WEIGHT_W];
   assign next_ptr    = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
   assign loadable    = !out_valid_q || bus.out_ready;

   // Eligibility is only re-evaluated between packets; a started packet always runs to its last beat.
   always_comb begin
      ready = '0;
      if (!axi_reset && state == BUSY && loadable && (mid_pkt || elig[grant]))
         ready[grant] = 1'b1;
   end

   assign accept    = |(bus.ch_valid & ready);
   assign beat_last = bus.ch_last[grant];

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         credit      <= '0;
         mid_pkt     <= 1'b0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant   <= pick;
                  credit  <= (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
                  mid_pkt <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (accept) begin
                  if (beat_last) begin
                     mid_pkt <= 1'b0;
                     if (credit == WEIGHT_W'(1)) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                     end else begin
                        credit <= credit - WEIGHT_W'(1);
                     end
                  end else begin
                     mid_pkt <= 1'b1;
                  end
               end else if (!mid_pkt && !elig[grant]) begin
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.ch_data[int'(grant)*DATA_W +: DATA_W];
            out_ch_q    <= grant;
            out_last_q  <= beat_last;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         // Only one channel is ever granted, so increment and decrement never coincide.
         if (DEP_EN != 0 && accept && beat_last) begin
            if (grant == CH_W'(DEP_SRC_CH))
               cnt <= cnt + CNT_W'(1);
            else if (grant == CH_W'(DEP_DST_CH))
               cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign bus.ch_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_last  = out_last_q;
   assign bus.outst_cnt = cnt;
endmodule

// File: tb/tb_slink_axi_chan_arb.sv
// Bench for slink_axi_chan_arb: per-channel packet queues, a transaction-level turn model
// producing the expected beat order, and immediate assertions at every comparison point.
module tb_slink_axi_chan_arb;
   localparam int NCH  = 3;
   localparam int DW   = 120;
   localparam int WW   = 4;
   localparam int MAXO = 8;
   localparam int BIG  = 1 << 30;

   typedef struct {
      logic [DW-1:0] dat;
      logic          last;
   } beat_t;

   typedef struct {
      int            ch;
      logic [DW-1:0] dat;
      logic          last;
      int            cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   slink_axi_chan_arb_if #(.NUM_CH(NCH), .DATA_W(DW), .WEIGHT_W(WW), .MAX_OUTST(MAXO)) bus ();

   slink_axi_chan_arb #(
      .NUM_CH(NCH), .DATA_W(DW), .WEIGHT_W(WW), .DEP_EN(1),
      .DEP_SRC_CH(0), .DEP_DST_CH(1), .MAX_OUTST(MAXO)
   ) dut (
      .axi_clk   (clk),
      .axi_reset (rst),
      .bus       (bus)
   );

   int      checks = 0;
   int      failures = 0;
   beat_t   chq[NCH][$];
   exp_t    expq[$];
   int      wgt[NCH];
   int      m_ptr = 0;
   int      m_cnt = 0;
   int      m_emitted = 0;
   int      phase_acc = 0;
   int      drop_at = BIG;
   logic    held = 1'b0;
   logic [DW-1:0] held_dat;
   logic [1:0]    held_ch;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int ch, input int len);
      beat_t        b;
      logic [127:0] r;
      for (int i = 0; i < len; i++) begin
         r      = {$urandom, $urandom, $urandom, $urandom};
         b.dat  = r[DW-1:0];
         b.last = (i == len - 1);
         chq[ch].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NCH; i++) begin
         bus.ch_weight[i*WW +: WW] = WW'(wgt[i]);
         if (chq[i].size() > 0) begin
            bus.ch_valid[i]           = 1'b1;
            bus.ch_last[i]            = chq[i][0].last;
            bus.ch_data[i*DW +: DW]   = chq[i][0].dat;
         end else begin
            bus.ch_valid[i]           = 1'b0;
            bus.ch_last[i]            = 1'b0;
            bus.ch_data[i*DW +: DW]   = '0;
         end
      end
   endtask

   // A channel may start a packet if it has data, enable is up, and the AW/W ordering allows it.
   function automatic bit m_elig(input int ch, input int sz);
      return sz > 0 && m_emitted < drop_at && !(ch == 1 && m_cnt == 0) && !(ch == 0 && m_cnt == MAXO);
   endfunction

   task automatic model_phase();
      beat_t mq[NCH][$];
      beat_t b;
      exp_t  e;
      int    ch;
      int    credit;
      int    c;
      bit    found;
      bit    turn_done;
      for (int i = 0; i < NCH; i++) mq[i] = chq[i];
      m_emitted = 0;
      while (1) begin
         found = 0;
         ch    = 0;
         for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (!found && m_elig(c, mq[c].size())) begin
               found = 1;
               ch    = c;
            end
         end
         if (!found) break;
         credit    = (wgt[ch] == 0) ? 1 : wgt[ch];
         turn_done = 0;
         while (!turn_done) begin
            do begin
               b = mq[ch].pop_front();
               m_emitted++;
               if (b.last && ch == 0) m_cnt++;
               else if (b.last && ch == 1) m_cnt--;
               e.ch = ch; e.dat = b.dat; e.last = b.last; e.cnt = m_cnt;
               expq.push_back(e);
            end while (!b.last);
            credit--;
            if (credit == 0 || !m_elig(ch, mq[ch].size())) begin
               m_ptr     = (ch + 1) % NCH;
               turn_done = 1;
            end
         end
      end
   endtask

   task automatic tick(input int rdy_pct, input bit force_low);
      logic [NCH-1:0] acc;
      exp_t           e;
      @(negedge clk);
      if (held) begin
         check("hold_vld", bus.out_valid, 1);
         check("hold_dat", bus.out_data, held_dat);
         check("hold_ch", bus.out_ch, held_ch);
      end
      acc = bus.ch_valid & bus.ch_ready;
      if (bus.out_valid && bus.out_ready) begin
         if (expq.size() == 0) begin
            check("extra_beat", 128'(bus.out_valid && bus.out_ready), 0);
         end else begin
            e = expq.pop_front();
            check("beat_ch", bus.out_ch, e.ch);
            check("beat_dat", bus.out_data, e.dat);
            check("beat_last", bus.out_last, e.last);
            check("beat_outst", bus.outst_cnt, e.cnt);
         end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_dat = bus.out_data;
      held_ch  = bus.out_ch;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         if (acc[i]) begin
            chq[i].delete(0);
            phase_acc++;
         end
      end
      if (phase_acc >= drop_at) bus.enable = 1'b0;
      bus.out_ready = force_low ? 1'b0 : ($urandom_range(99) < rdy_pct);
      drive();
   endtask

   task automatic run_phase(input int drop, input int rdy_pct);
      drop_at    = drop;
      phase_acc  = 0;
      bus.enable = 1'b1;
      model_phase();
      drive();
      for (int c = 0; c < 800 && expq.size() > 0; c++)
         tick(rdy_pct, c >= 6 && c <= 10);
      check("drained", expq.size(), 0);
      expq.delete();
      for (int c = 0; c < 8; c++) tick(100, 1'b0);
      check("phase_outst", bus.outst_cnt, m_cnt);
      check("phase_accepts", phase_acc, m_emitted);
   endtask

   initial begin
      rst           = 1'b1;
      wgt           = '{1, 1, 1};
      bus.enable    = 1'b1;
      bus.ch_valid  = '1;
      bus.ch_last   = '1;
      bus.ch_data   = '1;
      bus.ch_weight = '0;
      bus.out_ready = 1'b1;

      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_ch_ready", bus.ch_ready, 0);
         check("rst_outst", bus.outst_cnt, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive();
      @(negedge clk);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_ch", bus.out_ch, 0);
      check("rst_out_last", bus.out_last, 0);
      @(posedge clk);
      #1;

      // W waiting with no AW ahead of it must not move.
      add_pkt(1, 4);
      run_phase(BIG, 100);
      check("w_blocked", chq[1].size(), 4);

      // One AW packet releases the W burst.
      add_pkt(0, 1);
      run_phase(BIG, 100);

      // Round robin between ch0 and ch2.
      for (int i = 0; i < 4; i++) begin
         add_pkt(0, 1);
         add_pkt(2, 1);
      end
      run_phase(BIG, 70);

      // Weighted turns, ch2 multi-beat packet kept whole.
      wgt = '{3, 1, 1};
      for (int i = 0; i < 4; i++) add_pkt(0, 1);
      add_pkt(2, 4);
      add_pkt(2, 1);
      run_phase(BIG, 80);

      wgt = '{1, 8, 1};
      for (int i = 0; i < 8; i++) add_pkt(1, $urandom_range(1, 4));
      run_phase(BIG, 60);

      // Saturation: the ninth AW waits until a W completes.
      wgt = '{15, 1, 1};
      for (int i = 0; i < 9; i++) add_pkt(0, 1);
      run_phase(BIG, 100);
      check("aw_blocked", chq[0].size(), 1);
      check("sat_outst", bus.outst_cnt, MAXO);
      add_pkt(1, 4);
      run_phase(BIG, 100);

      wgt = '{1, 8, 1};
      for (int i = 0; i < 8; i++) add_pkt(1, $urandom_range(1, 4));
      run_phase(BIG, 50);

      // enable drops mid-packet on ch2: packet completes, ch0 is not granted.
      wgt = '{1, 1, 2};
      add_pkt(2, 4);
      add_pkt(0, 1);
      run_phase(2, 50);
      check("en_left", chq[0].size(), 1);
      run_phase(BIG, 100);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NCH; i++) begin
            wgt[i] = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) add_pkt(i, $urandom_range(1, 4));
         end
         run_phase(BIG, $urandom_range(30, 100));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
